// File: rtl/comparator_serial_nbit.sv
// Sequential magnitude comparator: scans two WIDTH-bit operands MSB-first,
// STEP bits per clock, with optional early exit at the first differing chunk.
// Signed compares are reduced to unsigned ones by flipping both operand MSBs
// at capture time, so the scan datapath itself never knows about signedness.
module comparator_serial_nbit #(
   parameter int WIDTH      = 8,
   parameter int STEP       = 1,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             greater,
   output logic             less,
   output logic             equal
);

   localparam int N  = WIDTH / STEP;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CW-1:0]    LAST_IDX = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPARE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic             diff_seen_q, diff_seen_d;
   logic             diff_gt_q, diff_gt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             greater_q, greater_d;
   logic             less_q, less_d;
   logic             equal_q, equal_d;

   logic [STEP-1:0]  chunk_a_s;
   logic [STEP-1:0]  chunk_b_s;
   logic             chunk_differ_s;
   logic             chunk_gt_s;
   logic             decide_s;

   // Next-state, shift-register and result computation for the whole FSM.
   always_comb begin
      state_d        = state_q;
      a_sh_d         = a_sh_q;
      b_sh_d         = b_sh_q;
      idx_d          = idx_q;
      diff_seen_d    = diff_seen_q;
      diff_gt_d      = diff_gt_q;
      busy_d         = busy_q;
      done_d         = 1'b0;
      greater_d      = greater_q;
      less_d         = less_q;
      equal_d        = equal_q;
      decide_s       = 1'b0;
      chunk_a_s      = a_sh_q[WIDTH-1 -: STEP];
      chunk_b_s      = b_sh_q[WIDTH-1 -: STEP];
      chunk_differ_s = (chunk_a_s != chunk_b_s);
      chunk_gt_s     = (chunk_a_s > chunk_b_s);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               // Flipping both MSBs maps two's-complement order onto unsigned order.
               a_sh_d      = signed_mode ? (a ^ MSB_MASK) : a;
               b_sh_d      = signed_mode ? (b ^ MSB_MASK) : b;
               idx_d       = '0;
               diff_seen_d = 1'b0;
               diff_gt_d   = 1'b0;
               busy_d      = 1'b1;
               state_d     = S_COMPARE;
            end else begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_COMPARE: begin
            decide_s = ((EARLY_EXIT != 0) && chunk_differ_s) || (idx_q == LAST_IDX);
            if (decide_s) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
               // The first differing chunk (recorded or current) decides the order.
               if (diff_seen_q) begin
                  greater_d = diff_gt_q;
                  less_d    = ~diff_gt_q;
                  equal_d   = 1'b0;
               end else if (chunk_differ_s) begin
                  greater_d = chunk_gt_s;
                  less_d    = ~chunk_gt_s;
                  equal_d   = 1'b0;
               end else begin
                  greater_d = 1'b0;
                  less_d    = 1'b0;
                  equal_d   = 1'b1;
               end
            end else begin
               a_sh_d = a_sh_q << STEP;
               b_sh_d = b_sh_q << STEP;
               idx_d  = idx_q + CW'(1);
               busy_d = 1'b1;
               if (chunk_differ_s && !diff_seen_q) begin
                  diff_seen_d = 1'b1;
                  diff_gt_d   = chunk_gt_s;
               end else begin
                  diff_seen_d = diff_seen_q;
                  diff_gt_d   = diff_gt_q;
               end
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered-output flops; reset abandons any compare in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         idx_q       <= '0;
         diff_seen_q <= 1'b0;
         diff_gt_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         greater_q   <= 1'b0;
         less_q      <= 1'b0;
         equal_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         idx_q       <= idx_d;
         diff_seen_q <= diff_seen_d;
         diff_gt_q   <= diff_gt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         greater_q   <= greater_d;
         less_q      <= less_d;
         equal_q     <= equal_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign greater = greater_q;
   assign less    = less_q;
   assign equal   = equal_q;

endmodule

// File: tb/tb_comparator_serial_nbit.sv
// Bench for comparator_serial_nbit: seven instances covering STEP/EARLY_EXIT
// combinations, a directed vector table, hand-written multi-cycle sequences
// and a random regression against an arithmetic reference model.
module tb_comparator_serial_nbit;

   function automatic int step_of(input int g);
      case (g)
         0, 1:    return 1;
         2, 3:    return 2;
         4, 5:    return 8;
         default: return 4;
      endcase
   endfunction

   function automatic int ee_of(input int g);
      return (g == 0 || g == 2 || g == 4) ? 1 : 0;
   endfunction

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] start_v;
   logic       signed_mode;
   logic [7:0] a, b;
   logic [6:0] busy_v, done_v, gt_v, lt_v, eq_v;

   int n_checks = 0;
   int n_fail   = 0;
   int lat_r [7];
   logic [6:0] bad_r;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 7; g++) begin : g_dut
      comparator_serial_nbit #(
         .WIDTH(8), .STEP(step_of(g)), .EARLY_EXIT(ee_of(g))
      ) u_dut (
         .clk(clk), .rst_n(rst_n), .start(start_v[g]), .signed_mode(signed_mode),
         .a(a), .b(b), .busy(busy_v[g]), .done(done_v[g]),
         .greater(gt_v[g]), .less(lt_v[g]), .equal(eq_v[g])
      );
   end

   typedef struct {
      int         inst;
      logic [7:0] va;
      logic [7:0] vb;
      logic       sm;
      logic [2:0] gle;
      int         lat;
   } vec_t;

   vec_t tbl [10];

   // Reference result {greater, less, equal} from plain signed/unsigned compare.
   function automatic logic [2:0] ref_gle(input logic [7:0] ra, input logic [7:0] rb, input logic rs);
      logic gt, lt;
      if (rs) begin
         gt = $signed(ra) > $signed(rb);
         lt = $signed(ra) < $signed(rb);
      end else begin
         gt = ra > rb;
         lt = ra < rb;
      end
      return {gt, lt, (ra == rb)};
   endfunction

   // Reference latency: index of first differing chunk plus one, or N.
   function automatic int ref_lat(input logic [7:0] ra, input logic [7:0] rb, input logic rs,
                                  input int st, input int ee);
      int n, ua, ub, mk, sh;
      n = 8 / st;
      if (ee == 0) return n;
      ua = rs ? (int'(ra) ^ 128) : int'(ra);
      ub = rs ? (int'(rb) ^ 128) : int'(rb);
      mk = (1 << st) - 1;
      for (int k = 0; k < n; k++) begin
         sh = 8 - st * (k + 1);
         if (((ua >> sh) & mk) != ((ub >> sh) & mk)) return k + 1;
      end
      return n;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [7:0] ta, input logic [7:0] tb_, input logic tsm,
                         input logic [6:0] mask);
      a = ta;
      b = tb_;
      signed_mode = tsm;
      start_v = mask;
      tick();
      start_v = 7'd0;
      check("busy_after_start", int'(busy_v & mask), int'(mask));
      check("done_after_start", int'(done_v & mask), 0);
   endtask

   task automatic wait_all(input logic [6:0] mask, input logic tail);
      logic all_done;
      for (int g = 0; g < 7; g++) lat_r[g] = -1;
      bad_r = 7'd0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         all_done = 1'b1;
         for (int g = 0; g < 7; g++) begin
            if (mask[g]) begin
               if (lat_r[g] < 0) begin
                  if (done_v[g]) begin
                     lat_r[g] = c;
                     if (busy_v[g]) bad_r[g] = 1'b1;
                  end else if (!busy_v[g]) begin
                     bad_r[g] = 1'b1;
                  end
               end else if (done_v[g] || busy_v[g]) begin
                  bad_r[g] = 1'b1;
               end
               if (lat_r[g] < 0) all_done = 1'b0;
            end
         end
         if (all_done) break;
      end
      if (tail) begin
         tick();
         check("done_one_cycle", int'(done_v & mask), 0);
      end
      for (int g = 0; g < 7; g++)
         if (mask[g]) check($sformatf("protocol[%0d]", g), int'(bad_r[g]), 0);
   endtask

   task automatic check_model(input int g, input logic [7:0] ra, input logic [7:0] rb, input logic rs);
      check($sformatf("gle[%0d] a=%h b=%h s=%0d", g, ra, rb, rs),
            int'({gt_v[g], lt_v[g], eq_v[g]}), int'(ref_gle(ra, rb, rs)));
      check($sformatf("lat[%0d] a=%h b=%h s=%0d", g, ra, rb, rs),
            lat_r[g], ref_lat(ra, rb, rs, step_of(g), ee_of(g)));
   endtask

   initial begin
      int cnt;
      logic [7:0] ra, rb;
      logic       rs;

      tbl[0] = '{0, 8'h00, 8'h00, 1'b0, 3'b001, 8};
      tbl[1] = '{0, 8'h80, 8'h7F, 1'b0, 3'b100, 1};
      tbl[2] = '{0, 8'h80, 8'h7F, 1'b1, 3'b010, 1};
      tbl[3] = '{0, 8'h05, 8'h06, 1'b0, 3'b010, 7};
      tbl[4] = '{6, 8'h3C, 8'h4C, 1'b0, 3'b010, 2};
      tbl[5] = '{6, 8'hC3, 8'h33, 1'b1, 3'b010, 2};
      tbl[6] = '{0, 8'h00, 8'hFF, 1'b0, 3'b010, 1};
      tbl[7] = '{0, 8'h00, 8'hFF, 1'b1, 3'b100, 1};
      tbl[8] = '{1, 8'h80, 8'h7F, 1'b1, 3'b010, 8};
      tbl[9] = '{4, 8'h7F, 8'h80, 1'b1, 3'b100, 1};

      rst_n = 1'b0;
      start_v = 7'd0;
      signed_mode = 1'b0;
      a = 8'h00;
      b = 8'h00;
      #12;
      check("reset_outputs", int'({busy_v, done_v, gt_v, lt_v, eq_v}), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Directed vectors
      for (int i = 0; i < 10; i++) begin
         launch(tbl[i].va, tbl[i].vb, tbl[i].sm, 7'd1 << tbl[i].inst);
         wait_all(7'd1 << tbl[i].inst, 1'b1);
         check($sformatf("tbl%0d_gle", i),
               int'({gt_v[tbl[i].inst], lt_v[tbl[i].inst], eq_v[tbl[i].inst]}), int'(tbl[i].gle));
         check($sformatf("tbl%0d_lat", i), lat_r[tbl[i].inst], tbl[i].lat);
      end

      // Start during COMPARE is ignored; operands stay latched
      launch(8'h05, 8'h06, 1'b0, 7'd1);
      tick();
      a = 8'hFF;
      b = 8'h00;
      start_v = 7'd1;
      tick();
      start_v = 7'd0;
      wait_all(7'd1, 1'b0);
      check("ignored_start_gle", int'({gt_v[0], lt_v[0], eq_v[0]}), 3'b010);
      check("ignored_start_lat", lat_r[0], 5);

      // Back-to-back: new start accepted in the DONE cycle
      launch(8'hFF, 8'hFE, 1'b0, 7'd1);
      wait_all(7'd1, 1'b1);
      check("b2b_gle", int'({gt_v[0], lt_v[0], eq_v[0]}), 3'b100);
      check("b2b_lat", lat_r[0], 8);

      // Asynchronous reset in the middle of a compare
      launch(8'h00, 8'h00, 1'b0, 7'd1);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_outputs", int'({busy_v[0], done_v[0], gt_v[0], lt_v[0], eq_v[0]}), 0);
      tick();
      rst_n = 1'b1;
      cnt = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done_v[0] || busy_v[0]) cnt++;
      end
      check("no_done_after_reset", cnt, 0);

      // Random regression across STEP={1,2,8} x EARLY_EXIT={1,0}
      for (int t = 0; t < 1000; t++) begin
         ra = 8'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
         rs = 1'($urandom);
         launch(ra, rb, rs, 7'h3F);
         wait_all(7'h3F, 1'b1);
         for (int g = 0; g < 6; g++) check_model(g, ra, rb, rs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
